// File: rtl/comparador_hist_dms.sv
// Multi-channel hysteretic comparator with a per-channel sample filter and a
// single-slot event register that reports each output toggle to a consumer.
module comparador_hist_dms #(
  parameter int  N_CH     = 4,
  parameter real HYST     = 0.02,
  parameter int  FILT_LEN = 3,
  localparam int CW       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  real           p_i [N_CH],
  input  real           n_i [N_CH],
  output logic [N_CH-1:0] c_o,
  output logic          evt_valid_o,
  input  logic          evt_ready_i,
  output logic [CW-1:0] evt_ch_o,
  output logic          evt_dir_o,
  output logic          ovf_o
);

  typedef enum logic {ST_STABLE, ST_PEND} state_e;

  localparam logic [3:0] CNT_LAST = 4'(FILT_LEN - 1);

  state_e          state_q [N_CH];
  state_e          state_d [N_CH];
  logic [3:0]      cnt_q   [N_CH];
  logic [3:0]      cnt_d   [N_CH];
  logic [N_CH-1:0] c_q, c_d;
  logic [N_CH-1:0] raw, tog;
  logic [N_CH-1:0] pend_q, pend_d;
  logic [N_CH-1:0] dir_q, dir_d;
  logic            evt_valid_q, evt_valid_d;
  logic [CW-1:0]   evt_ch_q, evt_ch_d;
  logic            evt_dir_q, evt_dir_d;
  logic            ovf_q, ovf_d;

  logic            load;
  logic            found;
  logic [CW-1:0]   sel;

  // Raw decision: the threshold that matters depends on the current output.
  always_comb begin
    raw = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (c_q[i]) raw[i] = !((p_i[i] - n_i[i]) < -(HYST / 2.0));
      else        raw[i] =   (p_i[i] - n_i[i]) >  (HYST / 2.0);
    end
  end

  // NOTE: every always_comb output gets a default before any branch; a path
  // that leaves a variable unassigned would infer a latch.
  always_comb begin
    tog = '0;
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (en_i) begin
        case (state_q[i])
          ST_STABLE: begin
            if (raw[i] != c_q[i]) begin
              if (FILT_LEN == 1) begin
                tog[i] = 1'b1;
              end else begin
                cnt_d[i]   = 4'd1;
                state_d[i] = ST_PEND;
              end
            end
          end
          ST_PEND: begin
            if (raw[i] == c_q[i]) begin
              cnt_d[i]   = 4'd0;
              state_d[i] = ST_STABLE;
            end else if (cnt_q[i] == CNT_LAST) begin
              tog[i]     = 1'b1;
              cnt_d[i]   = 4'd0;
              state_d[i] = ST_STABLE;
            end else begin
              cnt_d[i] = cnt_q[i] + 4'd1;
            end
          end
          default: begin
            cnt_d[i]   = 4'd0;
            state_d[i] = ST_STABLE;
          end
        endcase
      end
    end
    c_d = c_q ^ tog;
  end

  // Event slot: reload whenever it is empty or being accepted this edge.
  always_comb begin
    load        = !evt_valid_q || evt_ready_i;
    found       = 1'b0;
    sel         = '0;
    pend_d      = pend_q;
    dir_d       = dir_q;
    ovf_d       = ovf_q;
    evt_valid_d = evt_valid_q;
    evt_ch_d    = evt_ch_q;
    evt_dir_d   = evt_dir_q;

    for (int i = 0; i < N_CH; i++) begin
      if (!found && pend_q[i]) begin
        found = 1'b1;
        sel   = CW'(i);
      end
    end

    if (load) begin
      evt_valid_d = found;
      if (found) begin
        evt_ch_d    = sel;
        evt_dir_d   = dir_q[sel];
        pend_d[sel] = 1'b0;
      end
    end

    // A toggle on a channel whose older event leaves this same edge is not
    // an overwrite: the old one is delivered and the new one stays pending.
    for (int i = 0; i < N_CH; i++) begin
      if (tog[i]) begin
        if (pend_q[i] && !(load && found && sel == CW'(i))) ovf_d = 1'b1;
        pend_d[i] = 1'b1;
        dir_d[i]  = c_d[i];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= ST_STABLE;
        cnt_q[i]   <= 4'd0;
      end
      c_q         <= '0;
      pend_q      <= '0;
      dir_q       <= '0;
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      evt_dir_q   <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      c_q         <= c_d;
      pend_q      <= pend_d;
      dir_q       <= dir_d;
      evt_valid_q <= evt_valid_d;
      evt_ch_q    <= evt_ch_d;
      evt_dir_q   <= evt_dir_d;
      ovf_q       <= ovf_d;
    end
  end

  assign c_o         = c_q;
  assign evt_valid_o = evt_valid_q;
  assign evt_ch_o    = evt_ch_q;
  assign evt_dir_o   = evt_dir_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_comparador_hist_dms.sv
// Scenario bench for comparador_hist_dms: expected events are queued as
// stimulus is driven and checked by a monitor as each handshake occurs.
module tb_comparador_hist_dms;

  localparam int N_CH = 4;

  typedef struct packed {
    logic [1:0] ch;
    logic       dir;
  } evt_t;

  logic            clk;
  logic            rst_n;
  logic            en;
  real             p [N_CH];
  real             n [N_CH];
  logic [N_CH-1:0] c;
  logic            evt_valid;
  logic            evt_ready;
  logic [1:0]      evt_ch;
  logic            evt_dir;
  logic            ovf;

  int   tests_run    = 0;
  int   tests_failed = 0;
  evt_t sb [$];

  comparador_hist_dms #(.N_CH(N_CH), .HYST(0.02), .FILT_LEN(3)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .en_i        (en),
    .p_i         (p),
    .n_i         (n),
    .c_o         (c),
    .evt_valid_o (evt_valid),
    .evt_ready_i (evt_ready),
    .evt_ch_o    (evt_ch),
    .evt_dir_o   (evt_dir),
    .ovf_o       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs only change 1ns after a rising edge, so a handshake seen here
  // completes at the following rising edge.
  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_evt: got ch=%0d dir=%0d, expected no event", evt_ch, evt_dir);
      end else begin
        evt_t e;
        e = sb.pop_front();
        if ({evt_ch, evt_dir} !== {e.ch, e.dir}) begin
          tests_failed++;
          $display("FAIL evt_order: got ch=%0d dir=%0d, expected ch=%0d dir=%0d",
                   evt_ch, evt_dir, e.ch, e.dir);
        end
      end
    end
  end

  task automatic tick(input int cycles = 1);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_d(input int ch, input real d);
    p[ch] = d;
    n[ch] = 0.0;
  endtask

  task automatic push_evt(input int ch, input logic dir);
    evt_t e;
    e.ch  = 2'(ch);
    e.dir = dir;
    sb.push_back(e);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    tests_run++;
    if ({c, evt_valid, evt_ch, evt_dir, ovf} !== 9'b0) begin
      tests_failed++;
      $display("FAIL reset_state: got c=%b v=%b ch=%0d dir=%b ovf=%b, expected all 0",
               c, evt_valid, evt_ch, evt_dir, ovf);
    end
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_latency;
    set_d(0, 0.05);
    push_evt(0, 1'b1);
    tick(1);
    tests_run++;
    if (c[0] !== 1'b0) begin tests_failed++; $display("FAIL lat_k: got %b expected 0", c[0]); end
    tick(1);
    tests_run++;
    if (c[0] !== 1'b0) begin tests_failed++; $display("FAIL lat_k1: got %b expected 0", c[0]); end
    tick(1);
    tests_run++;
    if ({c[0], evt_valid} !== 2'b10) begin
      tests_failed++;
      $display("FAIL lat_k2: got c0=%b v=%b expected c0=1 v=0", c[0], evt_valid);
    end
    tick(1);
    tests_run++;
    if ({evt_valid, evt_ch, evt_dir} !== 4'b1_00_1) begin
      tests_failed++;
      $display("FAIL lat_k3_evt: got v=%b ch=%0d dir=%b expected v=1 ch=0 dir=1",
               evt_valid, evt_ch, evt_dir);
    end
    tick(1);
    set_d(0, -0.05);
    push_evt(0, 1'b0);
    tick(3);
    tests_run++;
    if (c[0] !== 1'b0) begin tests_failed++; $display("FAIL lat_fall: got %b expected 0", c[0]); end
    set_d(0, 0.0);
    tick(3);
  endtask

  task automatic test_hysteresis;
    bit dropped = 1'b0;
    bit rose    = 1'b0;
    set_d(1, 0.05);
    push_evt(1, 1'b1);
    tick(3);
    tests_run++;
    if (c[1] !== 1'b1) begin tests_failed++; $display("FAIL hyst_rise: got %b expected 1", c[1]); end
    set_d(1, -0.005);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (c[1] !== 1'b1) dropped = 1'b1;
    end
    tests_run++;
    if (dropped) begin tests_failed++; $display("FAIL hyst_inside_low: got a drop, expected c1 held at 1"); end
    p[1] = 0.30;
    n[1] = 0.35;
    push_evt(1, 1'b0);
    tick(3);
    tests_run++;
    if (c[1] !== 1'b0) begin tests_failed++; $display("FAIL hyst_fall: got %b expected 0", c[1]); end
    set_d(1, 0.01);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (c[1] !== 1'b0) rose = 1'b1;
    end
    tests_run++;
    if (rose) begin tests_failed++; $display("FAIL hyst_exact_thr: got a rise, expected c1 held at 0"); end
    set_d(1, 0.0);
    tick(2);
  endtask

  task automatic test_glitch;
    set_d(2, 0.05);
    tick(2);
    set_d(2, 0.0);
    tick(5);
    tests_run++;
    if ({c[2], evt_valid} !== 2'b00) begin
      tests_failed++;
      $display("FAIL glitch: got c2=%b v=%b expected c2=0 v=0", c[2], evt_valid);
    end
    set_d(2, 0.05);
    push_evt(2, 1'b1);
    tick(2);
    tests_run++;
    if (c[2] !== 1'b0) begin tests_failed++; $display("FAIL glitch_cnt_cleared: got %b expected 0", c[2]); end
    tick(1);
    tests_run++;
    if (c[2] !== 1'b1) begin tests_failed++; $display("FAIL glitch_refilter: got %b expected 1", c[2]); end
    set_d(2, -0.05);
    push_evt(2, 1'b0);
    tick(3);
    set_d(2, 0.0);
    tick(3);
  endtask

  task automatic test_enable;
    set_d(3, 0.05);
    push_evt(3, 1'b1);
    tick(1);
    en = 1'b0;
    tick(5);
    tests_run++;
    if (c[3] !== 1'b0) begin tests_failed++; $display("FAIL en_hold: got %b expected 0", c[3]); end
    en = 1'b1;
    tick(1);
    tests_run++;
    if (c[3] !== 1'b0) begin tests_failed++; $display("FAIL en_resume1: got %b expected 0", c[3]); end
    tick(1);
    tests_run++;
    if (c[3] !== 1'b1) begin tests_failed++; $display("FAIL en_resume2: got %b expected 1", c[3]); end
    set_d(3, -0.05);
    push_evt(3, 1'b0);
    tick(3);
    set_d(3, 0.0);
    tick(3);
  endtask

  task automatic test_back_to_back;
    set_d(0, 0.05);
    set_d(2, 0.05);
    push_evt(0, 1'b1);
    push_evt(2, 1'b1);
    tick(3);
    tests_run++;
    if (c[2:0] !== 3'b101) begin tests_failed++; $display("FAIL b2b_toggle: got %b expected 101", c[2:0]); end
    tick(1);
    tests_run++;
    if ({evt_valid, evt_ch} !== 3'b1_00) begin
      tests_failed++;
      $display("FAIL b2b_first: got v=%b ch=%0d expected v=1 ch=0", evt_valid, evt_ch);
    end
    tick(1);
    tests_run++;
    if ({evt_valid, evt_ch} !== 3'b1_10) begin
      tests_failed++;
      $display("FAIL b2b_second: got v=%b ch=%0d expected v=1 ch=2", evt_valid, evt_ch);
    end
    set_d(0, -0.05);
    set_d(2, -0.05);
    push_evt(0, 1'b0);
    push_evt(2, 1'b0);
    tick(6);
    set_d(0, 0.0);
    set_d(2, 0.0);
    tick(2);
  endtask

  task automatic test_overflow;
    evt_ready = 1'b0;
    set_d(1, 0.05);
    push_evt(1, 1'b1);
    tick(5);
    set_d(3, 0.05);
    tick(3);
    tests_run++;
    if ({c[3], ovf} !== 2'b10) begin
      tests_failed++;
      $display("FAIL ovf_first: got c3=%b ovf=%b expected c3=1 ovf=0", c[3], ovf);
    end
    set_d(3, -0.05);
    push_evt(3, 1'b0);
    tick(3);
    tests_run++;
    if ({c[3], ovf} !== 2'b01) begin
      tests_failed++;
      $display("FAIL ovf_set: got c3=%b ovf=%b expected c3=0 ovf=1", c[3], ovf);
    end
    tests_run++;
    if ({evt_valid, evt_ch, evt_dir} !== 4'b1_01_1) begin
      tests_failed++;
      $display("FAIL ovf_hold: got v=%b ch=%0d dir=%b expected v=1 ch=1 dir=1",
               evt_valid, evt_ch, evt_dir);
    end
    set_d(3, 0.0);
    evt_ready = 1'b1;
    tick(4);
    tests_run++;
    if ({evt_valid, ovf} !== 2'b01) begin
      tests_failed++;
      $display("FAIL ovf_sticky: got v=%b ovf=%b expected v=0 ovf=1", evt_valid, ovf);
    end
  endtask

  task automatic test_reset_mid;
    evt_ready = 1'b0;
    set_d(0, 0.05);
    tick(4);
    set_d(2, 0.05);
    tick(1);
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({c, evt_valid, evt_ch, evt_dir, ovf} !== 9'b0) begin
      tests_failed++;
      $display("FAIL rst_mid: got c=%b v=%b ch=%0d dir=%b ovf=%b expected all 0",
               c, evt_valid, evt_ch, evt_dir, ovf);
    end
    for (int i = 0; i < N_CH; i++) set_d(i, 0.0);
    set_d(1, 0.05);
    set_d(1, 0.0);
    tick(2);
    rst_n = 1'b1;
    evt_ready = 1'b1;
    tick(6);
    tests_run++;
    if ({c, evt_valid} !== 5'b0) begin
      tests_failed++;
      $display("FAIL rst_post: got c=%b v=%b expected 0", c, evt_valid);
    end
    set_d(2, 0.05);
    push_evt(2, 1'b1);
    tick(2);
    tests_run++;
    if (c[2] !== 1'b0) begin tests_failed++; $display("FAIL rst_fresh_pend: got %b expected 0", c[2]); end
    tick(1);
    tests_run++;
    if (c[2] !== 1'b1) begin tests_failed++; $display("FAIL rst_fresh_toggle: got %b expected 1", c[2]); end
  endtask

  initial begin
    en        = 1'b1;
    evt_ready = 1'b1;
    for (int i = 0; i < N_CH; i++) set_d(i, 0.0);

    test_reset();
    test_latency();
    test_hysteresis();
    test_glitch();
    test_enable();
    test_back_to_back();
    test_overflow();
    test_reset_mid();

    for (int i = 0; i < 20 && sb.size() != 0; i++) tick(1);
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: got %0d events still expected, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/comparador_hist_dms.md
COMPARADOR_HIST_DMS -- requirements
Module: comparador_hist_dms

Interface
REQ-001 Parameter N_CH, default 4, number of independent comparator channels (1..16).
REQ-002 Parameter HYST, default 0.02 (real), full hysteresis window; thresholds are +HYST/2 and -HYST/2 on (p-n).
REQ-003 Parameter FILT_LEN, default 3, consecutive samples required before an output toggles (1..15).
REQ-004 clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 rst_ni  input  1  asynchronous reset, active-low.
REQ-006 en_i  input  1  sample enable; when low, all channel state holds.
REQ-007 p_i  input  real[N_CH]  positive analog input per channel.
REQ-008 n_i  input  real[N_CH]  negative analog input per channel.
REQ-009 c_o  output  N_CH  filtered comparator decision per channel.
REQ-010 evt_valid_o  output  1  event record available.
REQ-011 evt_ready_i  input  1  consumer accepts event when high with evt_valid_o.
REQ-012 evt_ch_o  output  $clog2(N_CH) (min 1)  channel index of presented event.
REQ-013 evt_dir_o  output  1  1 = rising (c_o 0->1), 0 = falling.
REQ-014 ovf_o  output  1  sticky: an event was overwritten before delivery.

Function
REQ-015 Per channel, d = p_i - n_i is sampled on each rising clk_i with en_i high.
REQ-016 Raw decision: with c_o=0, raw=1 only if d > +HYST/2 (strict); with c_o=1, raw=0 only if d < -HYST/2 (strict); otherwise raw = c_o.
REQ-017 Per-channel FSM states: STABLE, PEND; 4-bit filter counter per channel.
REQ-018 STABLE: raw != c_o -> if FILT_LEN=1, toggle c_o this edge and stay STABLE; else counter=1, go PEND.
REQ-019 PEND: raw == c_o -> counter=0, go STABLE, c_o unchanged; raw != c_o and counter = FILT_LEN-1 -> toggle c_o, counter=0, go STABLE; else counter+1.
REQ-020 Latency: crossing first sampled at edge k -> c_o toggles at edge k+FILT_LEN-1 if held for all FILT_LEN samples.
REQ-021 en_i low: FSM, counter, c_o hold; a held PEND resumes counting when en_i returns.
REQ-022 Every c_o toggle sets that channel's pending bit and records its direction at the same edge.
REQ-023 Toggle on a channel whose pending bit is already set (undelivered): direction overwritten, ovf_o set; ovf_o clears only on reset.
REQ-024 Event register loads when evt_valid_o is low, or high with evt_ready_i high: lowest-index pending channel chosen, its pending bit cleared, evt_valid_o=1 next cycle.
REQ-025 evt_valid_o high with evt_ready_i low: evt_ch_o, evt_dir_o, evt_valid_o hold stable.
REQ-026 Pending bit set and cleared (loaded) for the same channel on the same edge: set wins; event presented is the older one, new one stays pending.
REQ-027 Accept with no pending channel: evt_valid_o drops to 0 next cycle.
REQ-028 Event delivery operates regardless of en_i.

Reset
REQ-029 rst_ni low, asynchronously: c_o=0, all FSMs STABLE, counters 0, pending bits 0, evt_valid_o=0, evt_ch_o=0, evt_dir_o=0, ovf_o=0.
REQ-030 Reset asserted mid-PEND or with an event presented discards all state; first post-reset sample starts from STABLE with c_o=0.

Verification
REQ-031 N_CH=4, HYST=0.02, FILT_LEN=3: ch0 d=0.05 held from edge k -> c_o[0]=1 at edge k+2; evt_valid_o=1, evt_ch_o=0, evt_dir_o=1 at k+3.
REQ-032 Hysteresis: c_o[1]=1, d=-0.005 for 10 cycles -> c_o[1] stays 1; d=0.01 exactly from c_o=0 -> no toggle.
REQ-033 Glitch: d=0.05 for 2 cycles then 0.0 -> c_o unchanged, no event, counter back to 0.
REQ-034 Ch2 and ch0 toggle same edge, evt_ready_i=1 -> events delivered ch0 then ch2 on consecutive cycles.
REQ-035 evt_ready_i=0, ch3 toggles 1 then 0 -> ovf_o=1; after ready, one ch3 event with evt_dir_o=0 delivered.
REQ-036 rst_ni pulsed low mid-PEND with evt_valid_o=1 -> all outputs 0 immediately, no event after release.
